yapp_input_arbiter: RTL and testbench

//  Shares the router's single YAPP input channel among NUM_SRC packet sources.

---
 rtl/yapp_input_arbiter.sv | 177 +++++++++++++++++
 tb/tb_yapp_input_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yapp_input_arbiter.sv
// Packet-level round-robin arbiter that shares one YAPP router input among NUM_SRC sources.
// Whole packets are granted at a time; a minimum idle gap separates consecutive packets.
module yapp_input_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_vld,
    output logic [NUM_SRC-1:0]   src_rdy,
    input  logic [NUM_SRC-1:0]   src_en,
    output logic [7:0]           in_data,
    output logic                 in_data_vld,
    input  logic                 in_suspend,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic [NUM_SRC*8-1:0] pkt_cnt,
    output logic                 stall_err
);

    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_SRC-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   last_grant_reg, last_grant_next;
    logic               first_reg, first_next;
    logic [6:0]         remaining_reg, remaining_next;
    logic [3:0]         gapcnt_reg, gapcnt_next;
    logic               vld_prev_reg;

    logic               in_xfer;
    logic               cur_vld;
    logic [7:0]         cur_data;
    logic [IDX_W-1:0]   grant_idx;
    logic               xfer;
    logic               pkt_done;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] pick_onehot;
    logic               pick_vld;

    assign in_xfer = (state_reg == XFER);
    assign cur_vld = |(src_vld & grant_reg);
    assign xfer    = in_xfer & cur_vld & ~in_suspend;
    assign req     = src_vld & src_en;

    // Grant is one-hot, so an AND-OR mux selects the owner's byte.
    always_comb begin
        cur_data  = 8'h00;
        grant_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_reg[i]) begin
                cur_data  = cur_data | src_data[i*8 +: 8];
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Rotating priority: lowest requester above last_grant wins, else lowest at/below it.
    always_comb begin
        pick_onehot = '0;
        pick_vld    = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(last_grant_reg))) begin
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_vld       = 1'b1;
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last_grant_reg))) begin
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_vld       = 1'b1;
            end
        end
    end

    assign pkt_done = xfer & ~first_reg & (remaining_reg == 7'd1);

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        first_next      = first_reg;
        remaining_next  = remaining_reg;
        gapcnt_next     = gapcnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_vld) begin
                    grant_next = pick_onehot;
                    first_next = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (xfer) begin
                    if (first_reg) begin
                        remaining_next = {1'b0, cur_data[7:2]} + 7'd1;
                        first_next     = 1'b0;
                    end else if (remaining_reg == 7'd1) begin
                        remaining_next  = 7'd0;
                        last_grant_next = grant_idx;
                        gapcnt_next     = 4'(GAP_CYCLES);
                        state_next      = GAP;
                    end else begin
                        remaining_next = remaining_reg - 7'd1;
                    end
                end
            end
            GAP: begin
                if (gapcnt_reg <= 4'd1) begin
                    gapcnt_next = 4'd0;
                    grant_next  = '0;
                    state_next  = IDLE;
                end else begin
                    gapcnt_next = gapcnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_SRC - 1);
            first_reg      <= 1'b0;
            remaining_reg  <= 7'd0;
            gapcnt_reg     <= 4'd0;
            vld_prev_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            first_reg      <= first_next;
            remaining_reg  <= remaining_next;
            gapcnt_reg     <= gapcnt_next;
            vld_prev_reg   <= cur_vld;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [7:0] cnt_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_reg <= 8'd0;
                end else if (pkt_done && grant_reg[gi]) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end

            assign pkt_cnt[gi*8 +: 8] = cnt_reg;
            assign src_rdy[gi]        = grant_reg[gi] & in_xfer & ~in_suspend;
        end
    endgenerate

    assign in_data     = cur_data;
    assign in_data_vld = in_xfer & cur_vld;
    assign grant       = grant_reg;
    assign busy        = (state_reg != IDLE);
    // Header cycle never counts: a stall is only a 1->0 drop after the header went out.
    assign stall_err   = in_xfer & ~first_reg & ~cur_vld & vld_prev_reg;

endmodule

// File: tb/tb_yapp_input_arbiter.sv
// Directed bench for yapp_input_arbiter: table of single-packet vectors plus
// hand-written sequences for round-robin, suspend, stall, enable mask and reset.
module tb_yapp_input_arbiter;
    localparam int N = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [N*8-1:0] src_data;
    logic [N-1:0]  src_vld;
    logic [N-1:0]  src_rdy;
    logic [N-1:0]  src_en;
    logic [7:0]    in_data;
    logic          in_data_vld;
    logic          in_suspend;
    logic [N-1:0]  grant;
    logic          busy;
    logic [N*8-1:0] pkt_cnt;
    logic          stall_err;

    yapp_input_arbiter #(.NUM_SRC(N), .GAP_CYCLES(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .src_data   (src_data),
        .src_vld    (src_vld),
        .src_rdy    (src_rdy),
        .src_en     (src_en),
        .in_data    (in_data),
        .in_data_vld(in_data_vld),
        .in_suspend (in_suspend),
        .grant      (grant),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt),
        .stall_err  (stall_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         src;
        int         len;
        logic [2:0] exp_grant;
        int         exp_bytes;
        int         exp_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Source models: per-source list of packet lengths and a byte pointer.
    int plen[N][4];
    int pn[N];
    int pidx[N];
    int len_s[N];
    int size_s[N];
    int ptr_s[N];
    int seq_s[N];
    logic [N-1:0] hold;

    logic [7:0] obs_q[$];
    int         obs_src_q[$];
    logic [7:0] exp_q[$];
    int         exp_src_q[$];
    int         grant_order[$];

    int cyc = 0;
    int stall_cnt, gap_viol, parse_rem, pkt_bytes;
    bit need_gap;
    logic [N-1:0] prev_grant;
    logic busy_prev;
    int rise_cyc, first_byte_cyc, last_byte_cyc, busy_fall_cyc;
    logic [N-1:0] rise_grant;
    logic s_vld, s_busy;
    logic [N-1:0] s_rdy;
    logic [7:0] s_data;
    int ecnt[N];

    function automatic logic [7:0] pkt_byte(input int src, input int seq, input int len, input int k);
        logic [7:0] b;
        logic [7:0] p;
        p = 8'h00;
        for (int j = 0; j <= len; j++) begin
            if (j == 0) b = {6'(len), 2'(seq + 1)};
            else        b = 8'(src * 64 + seq * 16 + j * 7 + 3);
            if (j == k) return b;
            p = p ^ b;
        end
        return p;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (ptr_s[i] < size_s[i] || pidx[i] < pn[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load(input int src, input int len);
        plen[src][pn[src]] = len;
        pn[src]++;
    endtask

    task automatic push_exp(input int src, input int seq, input int len);
        for (int k = 0; k <= len + 1; k++) begin
            exp_q.push_back(pkt_byte(src, seq, len, k));
            exp_src_q.push_back(src);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (ptr_s[i] >= size_s[i] && pidx[i] < pn[i]) begin
                len_s[i]  = plen[i][pidx[i]];
                pidx[i]++;
                size_s[i] = len_s[i] + 2;
                ptr_s[i]  = 0;
                seq_s[i]++;
            end
            if (ptr_s[i] < size_s[i]) begin
                src_vld[i]         = ~hold[i];
                src_data[i*8 +: 8] = pkt_byte(i, seq_s[i], len_s[i], ptr_s[i]);
            end else begin
                src_vld[i]         = 1'b0;
                src_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clock);
        acc    = src_vld & src_rdy;
        s_vld  = in_data_vld;
        s_rdy  = src_rdy;
        s_data = in_data;
        s_busy = busy;
        if (grant !== '0 && prev_grant === '0) begin
            grant_order.push_back(oh_idx(grant));
            rise_cyc   = cyc;
            rise_grant = grant;
        end
        prev_grant = grant;
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        busy_prev = busy;
        if (stall_err === 1'b1) stall_cnt++;
        if (need_gap) begin
            if (in_data_vld !== 1'b0) gap_viol++;
            need_gap = 1'b0;
        end
        if (in_data_vld === 1'b1 && in_suspend === 1'b0) begin
            obs_q.push_back(in_data);
            obs_src_q.push_back(oh_idx(grant));
            if (obs_q.size() == 1) first_byte_cyc = cyc;
            last_byte_cyc = cyc;
            pkt_bytes++;
            if (parse_rem == 0) begin
                parse_rem = int'(in_data[7:2]) + 1;
            end else begin
                parse_rem--;
                if (parse_rem == 0) begin
                    need_gap = 1'b1;
                    $display("pkt src=%0d bytes=%0d cyc=%0d", oh_idx(grant), pkt_bytes, cyc);
                    pkt_bytes = 0;
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) ptr_s[i]++;
        drive();
        cyc++;
    endtask

    task automatic run_idle(input int max, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(all_empty() && s_busy === 1'b0) && n < max);
        if (!(all_empty() && s_busy === 1'b0)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=done", name, n);
        end
    endtask

    task automatic run_until_obs(input int cnt, input int max, input string name);
        int n;
        n = 0;
        while (obs_q.size() < cnt && n < max) begin
            tick();
            n++;
        end
        if (obs_q.size() < cnt) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d bytes required=%0d", name, obs_q.size(), cnt);
        end
    endtask

    task automatic clear();
        obs_q.delete();
        obs_src_q.delete();
        exp_q.delete();
        exp_src_q.delete();
        grant_order.delete();
        stall_cnt = 0;
        gap_viol  = 0;
    endtask

    task automatic cmp_stream(input string name);
        int bad;
        bad = -1;
        chk({name, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && (obs_q[i] !== exp_q[i] || obs_src_q[i] != exp_src_q[i])) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data idx=%0d actual=%0h/src%0d expected=%0h/src%0d",
                     name, bad, obs_q[bad], obs_src_q[bad], exp_q[bad], exp_src_q[bad]);
        end
    endtask

    task automatic chk_cnts(input string name);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_cnt%0d", name, i), pkt_cnt[i*8 +: 8], ecnt[i]);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{src: 0, len: 4,  exp_grant: 3'b001, exp_bytes: 6,  exp_cnt: 1};
        vecs[1] = '{src: 1, len: 0,  exp_grant: 3'b010, exp_bytes: 2,  exp_cnt: 1};
        vecs[2] = '{src: 2, len: 63, exp_grant: 3'b100, exp_bytes: 65, exp_cnt: 1};
        vecs[3] = '{src: 0, len: 10, exp_grant: 3'b001, exp_bytes: 12, exp_cnt: 2};
        vecs[4] = '{src: 2, len: 1,  exp_grant: 3'b100, exp_bytes: 3,  exp_cnt: 2};

        for (int i = 0; i < N; i++) begin
            pn[i] = 0; pidx[i] = 0; len_s[i] = 0; size_s[i] = 0; ptr_s[i] = 0; seq_s[i] = -1;
        end
        hold = '0; parse_rem = 0; pkt_bytes = 0; need_gap = 0;
        prev_grant = '0; busy_prev = 1'b0;
        reset = 1'b1; src_vld = '0; src_data = '0; src_en = 3'b111; in_suspend = 1'b0;
        clear();

        repeat (3) @(posedge clock);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_err, 0);
        chk("rst_pktcnt", pkt_cnt, 0);
        chk("rst_vld", in_data_vld, 0);
        chk("rst_rdy", src_rdy, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single-packet vectors: latency, contiguity, gap length and count.
        for (int v = 0; v < 5; v++) begin
            int start;
            string nm;
            nm = $sformatf("vec%0d", v);
            clear();
            push_exp(vecs[v].src, seq_s[vecs[v].src] + 1, vecs[v].len);
            load(vecs[v].src, vecs[v].len);
            drive();
            start = cyc;
            run_idle(200, nm);
            chk({nm, "_lat"}, rise_cyc - start, 1);
            chk({nm, "_grant"}, rise_grant, vecs[v].exp_grant);
            chk({nm, "_bytes"}, obs_q.size(), vecs[v].exp_bytes);
            chk({nm, "_contig"}, last_byte_cyc - first_byte_cyc, vecs[v].exp_bytes - 1);
            chk({nm, "_idle_at"}, busy_fall_cyc - start, vecs[v].exp_bytes + 2);
            chk({nm, "_cnt"}, pkt_cnt[vecs[v].src*8 +: 8], vecs[v].exp_cnt);
            cmp_stream(nm);
        end
        ecnt[0] = 2; ecnt[1] = 1; ecnt[2] = 2;

        // All three sources request continuously, two packets each.
        begin
            int rr_len[N];
            int rr_exp[6];
            rr_len[0] = 3; rr_len[1] = 5; rr_len[2] = 2;
            rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 2; rr_exp[3] = 0; rr_exp[4] = 1; rr_exp[5] = 2;
            clear();
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < N; i++) push_exp(i, seq_s[i] + 1 + r, rr_len[i]);
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < N; i++) load(i, rr_len[i]);
            drive();
            run_idle(500, "rr");
            chk("rr_ngrants", grant_order.size(), 6);
            for (int k = 0; k < 6 && k < grant_order.size(); k++)
                chk($sformatf("rr_order%0d", k), grant_order[k], rr_exp[k]);
            cmp_stream("rr");
            chk("rr_gap", gap_viol, 0);
            ecnt[0] = 4; ecnt[1] = 3; ecnt[2] = 4;
            chk_cnts("rr");
        end

        // Suspend for 3 cycles after the 2nd payload byte of a len=10 packet.
        begin
            logic [7:0] held;
            clear();
            push_exp(0, seq_s[0] + 1, 10);
            load(0, 10);
            drive();
            run_until_obs(3, 50, "susp");
            in_suspend = 1'b1;
            held = pkt_byte(0, seq_s[0], 10, 3);
            for (int k = 0; k < 3; k++) begin
                tick();
                chk($sformatf("susp_rdy%0d", k), s_rdy, 0);
                chk($sformatf("susp_vld%0d", k), s_vld, 1);
                chk($sformatf("susp_data%0d", k), s_data, held);
            end
            in_suspend = 1'b0;
            run_idle(100, "susp");
            cmp_stream("susp");
            ecnt[0] = 5;
            chk_cnts("susp");
        end

        // Source 1 drops src_vld for 2 cycles mid-packet.
        clear();
        push_exp(1, seq_s[1] + 1, 6);
        load(1, 6);
        drive();
        run_until_obs(3, 50, "stall");
        hold[1] = 1'b1;
        drive();
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("stall_vld%0d", k), s_vld, 0);
        end
        hold[1] = 1'b0;
        drive();
        run_idle(100, "stall");
        chk("stall_pulses", stall_cnt, 1);
        cmp_stream("stall");
        ecnt[1] = 4;
        chk_cnts("stall");

        // Enable mask 101 with all requesting; mask toggled during the first packet.
        clear();
        src_en = 3'b101;
        push_exp(2, seq_s[2] + 1, 4);
        push_exp(0, seq_s[0] + 1, 4);
        load(0, 4); load(1, 4); load(2, 4);
        drive();
        run_until_obs(2, 50, "en");
        src_en = 3'b000;
        tick();
        tick();
        src_en = 3'b101;
        repeat (30) tick();
        chk("en_ngrants", grant_order.size(), 2);
        if (grant_order.size() >= 2) begin
            chk("en_order0", grant_order[0], 2);
            chk("en_order1", grant_order[1], 0);
        end
        cmp_stream("en");
        chk("en_src1_untouched", ptr_s[1], 0);
        clear();
        push_exp(1, seq_s[1], 4);
        src_en = 3'b111;
        run_idle(100, "en_drain");
        chk("en_drain_grant", grant_order.size() > 0 ? grant_order[0] : -1, 1);
        cmp_stream("en_drain");
        ecnt[0] = 6; ecnt[1] = 5; ecnt[2] = 5;
        chk_cnts("en");

        // Minimum and maximum packet lengths back to back.
        clear();
        push_exp(0, seq_s[0] + 1, 0);
        push_exp(0, seq_s[0] + 2, 63);
        load(0, 0); load(0, 63);
        drive();
        run_idle(400, "minmax");
        cmp_stream("minmax");
        chk("minmax_gap", gap_viol, 0);
        ecnt[0] = 8;
        chk_cnts("minmax");

        // Asynchronous reset in the middle of a packet, with a competitor waiting.
        clear();
        load(0, 20); load(1, 5);
        drive();
        run_until_obs(10, 50, "rstmid");
        reset = 1'b1;
        #1;
        chk("rstmid_grant", grant, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_stall", stall_err, 0);
        chk("rstmid_pktcnt", pkt_cnt, 0);
        chk("rstmid_vld", in_data_vld, 0);
        chk("rstmid_rdy", src_rdy, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        ptr_s[0] = 0; ptr_s[1] = 0;
        parse_rem = 0; pkt_bytes = 0; need_gap = 1'b0;
        prev_grant = '0; busy_prev = 1'b0;
        clear();
        push_exp(0, seq_s[0], 20);
        push_exp(1, seq_s[1], 5);
        drive();
        run_idle(200, "rstmid");
        chk("rstmid_first", grant_order.size() > 0 ? grant_order[0] : -1, 0);
        chk("rstmid_second", grant_order.size() > 1 ? grant_order[1] : -1, 1);
        cmp_stream("rstmid");
        ecnt[0] = 1; ecnt[1] = 1; ecnt[2] = 0;
        chk_cnts("rstmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
